// File: rtl/sensor_hub_pkg.sv
// Shared encodings for the sensor hub: FSM state codes, request opcodes,
// reply codes and the reply-buffer type handed from the core to the TX sequencer.
// Build option SENSOR_HUB_CHECKSUM_EN (see sensor_hub_core) widens replies by one XOR byte.
package sensor_hub_pkg;

   // FSM state codes; also the values exported on debug_state.
   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_RX_CMD    = 4'd1;
   localparam logic [3:0] ST_RX_SKIP   = 4'd2;
   localparam logic [3:0] ST_DECODE    = 4'd3;
   localparam logic [3:0] ST_SNS_START = 4'd4;
   localparam logic [3:0] ST_SNS_WAIT  = 4'd5;
   localparam logic [3:0] ST_TX_LOAD   = 4'd6;
   localparam logic [3:0] ST_TX_BUSY   = 4'd7;
   localparam logic [3:0] ST_TX_DONE   = 4'd8;

   // Command byte low nibble.
   localparam logic [3:0] OP_STATUS = 4'd3;
   localparam logic [3:0] OP_TEMP   = 4'd4;
   localparam logic [3:0] OP_HUM    = 4'd5;

   // First byte of every reply.
   localparam logic [7:0] RSP_OK      = 8'h00;
   localparam logic [7:0] RSP_HUM     = 8'h01;
   localparam logic [7:0] RSP_TEMP    = 8'h02;
   localparam logic [7:0] RSP_DTH_ERR = 8'h1F;
   localparam logic [7:0] RSP_CMD_ERR = 8'h2F;

   typedef logic [3:0][7:0] rsp_bytes_t;

   // Reply as handed to the TX sequencer; bytes[0] goes out first.
   typedef struct packed {
      logic [2:0] len;
      rsp_bytes_t bytes;
   } rsp_t;

   function automatic logic opcode_valid(input logic [3:0] op);
      return (op == OP_STATUS) || (op == OP_TEMP) || (op == OP_HUM);
   endfunction

endpackage

// File: rtl/sensor_hub_tx_seq.sv
// Reply sequencer: latches a reply on load_i and feeds it byte by byte to uart_tx.
// Latency: tx_start_o rises one cycle after the load; next byte loads one cycle after tx_evt_i.
// Backpressure: start/data held until tx_busy_i; next byte only after tx_evt_i (rising edge of uart Done).
// Ports: clk_i/rst_i (sync, active high); load_i + rsp_i reply in; tx_evt_i/tx_busy_i from uart_tx;
//        tx_dat_o/tx_start_o to uart_tx; idle_o high when no reply is in flight; state_o for debug.
module sensor_hub_tx_seq
   import sensor_hub_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  rsp_t       rsp_i,
   input  logic       tx_evt_i,
   input  logic       tx_busy_i,
   output logic [7:0] tx_dat_o,
   output logic       tx_start_o,
   output logic       idle_o,
   output logic [3:0] state_o
);

   logic [3:0] st_q, st_d;
   logic [1:0] idx_q, idx_d;
   rsp_t       buf_q, buf_d;
   logic [7:0] dat_q, dat_d;
   logic       start_q, start_d;

   always_comb begin
      st_d    = st_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      dat_d   = dat_q;
      start_d = start_q;
      case (st_q)
         ST_IDLE: begin
            if (load_i) begin
               buf_d = rsp_i;
               idx_d = 2'd0;
               st_d  = ST_TX_LOAD;
            end
         end
         ST_TX_LOAD: begin
            dat_d   = buf_q.bytes[idx_q];
            start_d = 1'b1;
            st_d    = ST_TX_BUSY;
         end
         ST_TX_BUSY: begin
            // uart_tx has taken the byte once it reports busy
            if (tx_busy_i) begin
               start_d = 1'b0;
               st_d    = ST_TX_DONE;
            end
         end
         ST_TX_DONE: begin
            if (tx_evt_i) begin
               idx_d = idx_q + 2'd1;
               if ({1'b0, idx_q} == buf_q.len - 3'd1) begin
                  st_d = ST_IDLE;
               end else begin
                  st_d = ST_TX_LOAD;
               end
            end
         end
         default: begin
            st_d    = ST_IDLE;
            start_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q    <= ST_IDLE;
         idx_q   <= 2'd0;
         buf_q   <= '0;
         dat_q   <= 8'h00;
         start_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         dat_q   <= dat_d;
         start_q <= start_d;
      end
   end

   assign tx_dat_o   = dat_q;
   assign tx_start_o = start_q;
   assign idle_o     = (st_q == ST_IDLE);
   assign state_o    = st_q;

endmodule

// File: rtl/sensor_hub_core.sv
// Sensor hub: decodes {address, command} UART requests, reads one DHT11 channel, replies via uart_tx.
// Latency: command byte -> o_Dth_Start 3 cycles; o_Tx_Start 1 cycle after the reply is latched.
// Backpressure: one request at a time; bytes arriving during a read or reply are dropped, not queued.
// Ports: i_Clock/i_Reset (sync, active high); i_Rx_Data/i_Rx_Done from uart_rx; i_Tx_Busy/i_Tx_Done
//        and o_Tx_Data/o_Tx_Start to uart_tx; i_Dth_* / o_Dth_Start per channel; debug_state/debug_rx_Data.
// Build option: define SENSOR_HUB_CHECKSUM_EN to append an XOR-of-all-bytes trailer to every reply.
module sensor_hub_core
   import sensor_hub_pkg::*;
#(
   parameter logic [7:0]  ADDRESS     = 8'h00,
   parameter int          N_SENSORS   = 4,
   parameter logic [23:0] SNS_TIMEOUT = 24'd5_000_000,
   parameter logic [23:0] RX_TIMEOUT  = 24'd1_000_000
) (
   input  logic                   i_Clock,
   input  logic                   i_Reset,
   input  logic [7:0]             i_Rx_Data,
   input  logic                   i_Rx_Done,
   input  logic                   i_Tx_Busy,
   input  logic                   i_Tx_Done,
   input  logic [32*N_SENSORS-1:0] i_Dth_Data,
   input  logic [N_SENSORS-1:0]   i_Dth_Done,
   input  logic [N_SENSORS-1:0]   i_Dth_Error,
   output logic [7:0]             o_Tx_Data,
   output logic                   o_Tx_Start,
   output logic [N_SENSORS-1:0]   o_Dth_Start,
   output logic [3:0]             debug_state,
   output logic [7:0]             debug_rx_Data
);

   logic [3:0]           state_q, state_d;
   logic [23:0]          cnt_q, cnt_d;
   logic                 rx_d_q, tx_d_q;
   logic [7:0]           rx_byte_q, rx_byte_d;
   logic [7:0]           cmd_q, cmd_d;
   logic [N_SENSORS-1:0] sel_q, sel_d;
   logic [N_SENSORS-1:0] dth_start_q, dth_start_d;

   logic                 rx_evt, tx_evt;
   logic [N_SENSORS-1:0] cmd_oh;
   logic [31:0]          sel_data;
   logic                 done_hit, err_hit;
   rsp_t                 rsp;
   logic                 rsp_load;
   logic                 tx_idle;
   logic [3:0]           tx_state;

   assign rx_evt = i_Rx_Done & ~rx_d_q;
   assign tx_evt = i_Tx_Done & ~tx_d_q;

   // Channel index from the command, one-hot; all-zero means index out of range.
   always_comb begin
      cmd_oh = '0;
      for (int k = 0; k < N_SENSORS; k++) begin
         if (cmd_q[7:4] == 4'(k)) cmd_oh[k] = 1'b1;
      end
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N_SENSORS; k++) begin
         if (sel_q[k]) sel_data = i_Dth_Data[32*k +: 32];
      end
   end

   // Only the selected channel can end the wait.
   assign done_hit = |(i_Dth_Done & sel_q);
   assign err_hit  = |(i_Dth_Error & sel_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_byte_d   = rx_byte_q;
      cmd_d       = cmd_q;
      sel_d       = sel_q;
      dth_start_d = dth_start_q;
      rsp         = '0;
      rsp_load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_evt) begin
               rx_byte_d = i_Rx_Data;
               cnt_d     = '0;
               state_d   = (i_Rx_Data == ADDRESS) ? ST_RX_CMD : ST_RX_SKIP;
            end
         end
         ST_RX_CMD: begin
            if (rx_evt) begin
               rx_byte_d = i_Rx_Data;
               cmd_d     = i_Rx_Data;
               state_d   = ST_DECODE;
            end else if (cnt_q == RX_TIMEOUT) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         ST_RX_SKIP: begin
            // Request for another board: swallow its command byte silently.
            if (rx_evt) begin
               rx_byte_d = i_Rx_Data;
               state_d   = ST_IDLE;
            end else if (cnt_q == RX_TIMEOUT) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         ST_DECODE: begin
            if (!opcode_valid(cmd_q[3:0]) || (cmd_oh == '0)) begin
               rsp.bytes[0] = RSP_CMD_ERR;
               rsp.len      = 3'd1;
               rsp_load     = 1'b1;
               state_d      = ST_TX_LOAD;
            end else begin
               sel_d   = cmd_oh;
               state_d = ST_SNS_START;
            end
         end
         ST_SNS_START: begin
            dth_start_d = sel_q;
            cnt_d       = '0;
            state_d     = ST_SNS_WAIT;
         end
         ST_SNS_WAIT: begin
            if (done_hit) begin
               case (cmd_q[3:0])
                  OP_TEMP: begin
                     rsp.bytes[0] = RSP_TEMP;
                     rsp.bytes[1] = sel_data[7:0];
                     rsp.bytes[2] = sel_data[15:8];
                     rsp.len      = 3'd3;
                  end
                  OP_HUM: begin
                     rsp.bytes[0] = RSP_HUM;
                     rsp.bytes[1] = sel_data[23:16];
                     rsp.bytes[2] = sel_data[31:24];
                     rsp.len      = 3'd3;
                  end
                  default: begin
                     // STATUS is the only other opcode that survives decode
                     rsp.bytes[0] = RSP_OK;
                     rsp.len      = 3'd1;
                  end
               endcase
               rsp_load    = 1'b1;
               dth_start_d = '0;
               state_d     = ST_TX_LOAD;
            end else if (err_hit || (cnt_q == SNS_TIMEOUT)) begin
               rsp.bytes[0] = RSP_DTH_ERR;
               rsp.len      = 3'd1;
               rsp_load     = 1'b1;
               dth_start_d  = '0;
               state_d      = ST_TX_LOAD;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         ST_TX_LOAD: begin
            // The sequencer owns the TX phases; wait here until it drains the reply.
            if (tx_idle) state_d = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            dth_start_d = '0;
         end
      endcase
`ifdef SENSOR_HUB_CHECKSUM_EN
      // Unused reply bytes are zero, so XOR over the first three covers every length.
      if (rsp_load) begin
         rsp.bytes[rsp.len[1:0]] = rsp.bytes[0] ^ rsp.bytes[1] ^ rsp.bytes[2];
         rsp.len                 = rsp.len + 3'd1;
      end
`endif
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rx_d_q      <= 1'b0;
         tx_d_q      <= 1'b0;
         rx_byte_q   <= 8'h00;
         cmd_q       <= 8'h00;
         sel_q       <= '0;
         dth_start_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_d_q      <= i_Rx_Done;
         tx_d_q      <= i_Tx_Done;
         rx_byte_q   <= rx_byte_d;
         cmd_q       <= cmd_d;
         sel_q       <= sel_d;
         dth_start_q <= dth_start_d;
      end
   end

   sensor_hub_tx_seq u_tx_seq (
      .clk_i      (i_Clock),
      .rst_i      (i_Reset),
      .load_i     (rsp_load),
      .rsp_i      (rsp),
      .tx_evt_i   (tx_evt),
      .tx_busy_i  (i_Tx_Busy),
      .tx_dat_o   (o_Tx_Data),
      .tx_start_o (o_Tx_Start),
      .idle_o     (tx_idle),
      .state_o    (tx_state)
   );

   assign o_Dth_Start   = dth_start_q;
   assign debug_rx_Data = rx_byte_q;
   // While replying, report the sequencer's fine-grained TX phase.
   assign debug_state   = (state_q == ST_TX_LOAD) ? tx_state : state_q;

endmodule

// File: tb/tb_sensor_hub_core.sv
// Directed bench for sensor_hub_core: request decoding, channel reads, replies, timeouts, reset abort.
// A small uart_tx model captures every transmitted byte into txq.
// Expected reply bytes are extended with the XOR trailer when SENSOR_HUB_CHECKSUM_EN is defined.
module tb_sensor_hub_core;

   localparam int          NS     = 4;
   localparam logic [23:0] SNS_TO = 24'd60;
   localparam logic [23:0] RX_TO  = 24'd40;
   localparam logic [3:0]  S_IDLE    = 4'd0;
   localparam logic [3:0]  S_RX_CMD  = 4'd1;
   localparam logic [3:0]  S_RX_SKIP = 4'd2;
   localparam logic [3:0]  S_TX_BUSY = 4'd7;

   logic            clk;
   logic            i_Reset;
   logic [7:0]      i_Rx_Data;
   logic            i_Rx_Done;
   logic            i_Tx_Busy;
   logic            i_Tx_Done;
   logic [32*NS-1:0] i_Dth_Data;
   logic [NS-1:0]   i_Dth_Done;
   logic [NS-1:0]   i_Dth_Error;
   logic [7:0]      o_Tx_Data;
   logic            o_Tx_Start;
   logic [NS-1:0]   o_Dth_Start;
   logic [3:0]      debug_state;
   logic [7:0]      debug_rx_Data;

   int total = 0;
   int bad   = 0;
   logic [7:0] txq[$];
   logic       tx_hold = 1'b0;

   sensor_hub_core #(
      .ADDRESS     (8'h00),
      .N_SENSORS   (NS),
      .SNS_TIMEOUT (SNS_TO),
      .RX_TIMEOUT  (RX_TO)
   ) dut (
      .i_Clock       (clk),
      .i_Reset       (i_Reset),
      .i_Rx_Data     (i_Rx_Data),
      .i_Rx_Done     (i_Rx_Done),
      .i_Tx_Busy     (i_Tx_Busy),
      .i_Tx_Done     (i_Tx_Done),
      .i_Dth_Data    (i_Dth_Data),
      .i_Dth_Done    (i_Dth_Done),
      .i_Dth_Error   (i_Dth_Error),
      .o_Tx_Data     (o_Tx_Data),
      .o_Tx_Start    (o_Tx_Start),
      .o_Dth_Start   (o_Dth_Start),
      .debug_state   (debug_state),
      .debug_rx_Data (debug_rx_Data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // uart_tx model: accept a started byte, stay busy 3 cycles, then pulse Done.
   initial begin
      i_Tx_Busy = 1'b0;
      i_Tx_Done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (o_Tx_Start && !i_Tx_Busy && !tx_hold && !i_Reset) begin
            txq.push_back(o_Tx_Data);
            i_Tx_Busy = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            i_Tx_Busy = 1'b0;
            i_Tx_Done = 1'b1;
            @(posedge clk); #1;
            i_Tx_Done = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_Rx_Data = b;
      i_Rx_Done = 1'b1;
      tick(1);
      i_Rx_Done = 1'b0;
      tick(1);
   endtask

   task automatic wait_start(output logic [NS-1:0] seen);
      int c = 0;
      while (o_Dth_Start == '0 && c < 20) begin tick(1); c++; end
      seen = o_Dth_Start;
   endtask

   task automatic wait_tx(input int n);
      int c = 0;
      while (txq.size() < n && c < 400) begin tick(1); c++; end
      tick(20);
   endtask

   task automatic test_reset;
      i_Reset = 1'b1; i_Rx_Data = 8'h00; i_Rx_Done = 1'b0;
      i_Dth_Data = '0; i_Dth_Done = '0; i_Dth_Error = '0;
      tick(3);
      total++; if (o_Tx_Data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", o_Tx_Data); end
      total++; if (o_Tx_Start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b exp=0", o_Tx_Start); end
      total++; if (o_Dth_Start !== 4'b0000) begin bad++; $display("FAIL reset_dth_start got=%b exp=0000", o_Dth_Start); end
      total++; if (debug_rx_Data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", debug_rx_Data); end
      total++; if (debug_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", debug_state, S_IDLE); end
      i_Reset = 1'b0;
      tick(2);
   endtask

   task automatic test_temp;
      logic [7:0] exp[$];
      txq.delete();
      i_Dth_Data[32*2 +: 32] = 32'h0300_1905;
      send_byte(8'h00);
      i_Rx_Data = 8'h24; i_Rx_Done = 1'b1;
      tick(1);
      i_Rx_Done = 1'b0;
      tick(1);
      total++; if (o_Dth_Start !== 4'b0000) begin bad++; $display("FAIL temp_start_early got=%b exp=0000", o_Dth_Start); end
      tick(1);
      total++; if (o_Dth_Start !== 4'b0100) begin bad++; $display("FAIL temp_start_lat3 got=%b exp=0100", o_Dth_Start); end
      tick(5);
      total++; if (o_Dth_Start !== 4'b0100) begin bad++; $display("FAIL temp_start_hold got=%b exp=0100", o_Dth_Start); end
      i_Dth_Done[2] = 1'b1;
      tick(1);
      i_Dth_Done[2] = 1'b0;
      total++; if (o_Dth_Start !== 4'b0000) begin bad++; $display("FAIL temp_start_clear got=%b exp=0000", o_Dth_Start); end
      exp = '{8'h02, 8'h05, 8'h19};
`ifdef SENSOR_HUB_CHECKSUM_EN
      exp.push_back(8'h1E);
`endif
      wait_tx(exp.size());
      total++; if (txq.size() !== exp.size()) begin bad++; $display("FAIL temp_len got=%0d exp=%0d", txq.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
         total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL temp_byte%0d got=%h exp=%h", i, txq[i], exp[i]); end
      end
      total++; if (debug_state !== S_IDLE) begin bad++; $display("FAIL temp_idle got=%0d exp=%0d", debug_state, S_IDLE); end
      total++; if (debug_rx_Data !== 8'h24) begin bad++; $display("FAIL temp_rx_data got=%h exp=24", debug_rx_Data); end
   endtask

   task automatic test_skip_status;
      logic [7:0]    exp[$];
      logic [NS-1:0] any, seen;
      txq.delete();
      any = '0;
      send_byte(8'h07);
      send_byte(8'h14);
      for (int i = 0; i < 20; i++) begin any |= o_Dth_Start; tick(1); end
      total++; if (any !== 4'b0000) begin bad++; $display("FAIL skip_no_start got=%b exp=0000", any); end
      total++; if (txq.size() !== 0) begin bad++; $display("FAIL skip_no_tx got=%0d exp=0", txq.size()); end
      total++; if (debug_state !== S_IDLE) begin bad++; $display("FAIL skip_idle got=%0d exp=%0d", debug_state, S_IDLE); end
      send_byte(8'h00);
      send_byte(8'h03);
      wait_start(seen);
      total++; if (seen !== 4'b0001) begin bad++; $display("FAIL status_start got=%b exp=0001", seen); end
      i_Dth_Done[0] = 1'b1;
      tick(1);
      i_Dth_Done[0] = 1'b0;
      exp = '{8'h00};
`ifdef SENSOR_HUB_CHECKSUM_EN
      exp.push_back(8'h00);
`endif
      wait_tx(exp.size());
      total++; if (txq.size() !== exp.size()) begin bad++; $display("FAIL status_len got=%0d exp=%0d", txq.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
         total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL status_byte%0d got=%h exp=%h", i, txq[i], exp[i]); end
      end
   endtask

   task automatic test_cmd_err;
      logic [7:0]    exp[$];
      logic [7:0]    cmds[2];
      logic [NS-1:0] any;
      cmds = '{8'h06, 8'h54};
      exp = '{8'h2F};
`ifdef SENSOR_HUB_CHECKSUM_EN
      exp.push_back(8'h2F);
`endif
      for (int c = 0; c < 2; c++) begin
         txq.delete();
         any = '0;
         send_byte(8'h00);
         send_byte(cmds[c]);
         for (int i = 0; i < 10; i++) begin any |= o_Dth_Start; tick(1); end
         total++; if (any !== 4'b0000) begin bad++; $display("FAIL cmderr%0d_no_start got=%b exp=0000", c, any); end
         wait_tx(exp.size());
         total++; if (txq.size() !== exp.size()) begin bad++; $display("FAIL cmderr%0d_len got=%0d exp=%0d", c, txq.size(), exp.size()); end
         for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
            total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL cmderr%0d_byte%0d got=%h exp=%h", c, i, txq[i], exp[i]); end
         end
      end
   endtask

   task automatic test_sns_timeout;
      logic [7:0]    exp[$];
      logic [NS-1:0] seen;
      txq.delete();
      send_byte(8'h00);
      send_byte(8'h15);
      wait_start(seen);
      total++; if (seen !== 4'b0010) begin bad++; $display("FAIL to_start got=%b exp=0010", seen); end
      tick(10);
      // other channels finishing must not end this read
      i_Dth_Done[0] = 1'b1; i_Dth_Error[3] = 1'b1;
      tick(1);
      i_Dth_Done[0] = 1'b0; i_Dth_Error[3] = 1'b0;
      tick(40);
      total++; if (txq.size() !== 0) begin bad++; $display("FAIL to_early_reply got=%0d exp=0", txq.size()); end
      total++; if (o_Dth_Start !== 4'b0010) begin bad++; $display("FAIL to_start_held got=%b exp=0010", o_Dth_Start); end
      exp = '{8'h1F};
`ifdef SENSOR_HUB_CHECKSUM_EN
      exp.push_back(8'h1F);
`endif
      wait_tx(exp.size());
      total++; if (txq.size() !== exp.size()) begin bad++; $display("FAIL to_len got=%0d exp=%0d", txq.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
         total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL to_byte%0d got=%h exp=%h", i, txq[i], exp[i]); end
      end
      total++; if (o_Dth_Start !== 4'b0000) begin bad++; $display("FAIL to_start_clear got=%b exp=0000", o_Dth_Start); end
   endtask

   task automatic test_done_and_error;
      logic [7:0]    exp[$];
      logic [NS-1:0] seen;
      txq.delete();
      i_Dth_Data[32*1 +: 32] = 32'h003C_1234;
      send_byte(8'h00);
      send_byte(8'h15);
      wait_start(seen);
      total++; if (seen !== 4'b0010) begin bad++; $display("FAIL de_start got=%b exp=0010", seen); end
      i_Dth_Done[1] = 1'b1; i_Dth_Error[1] = 1'b1;
      tick(1);
      i_Dth_Done[1] = 1'b0; i_Dth_Error[1] = 1'b0;
      exp = '{8'h01, 8'h3C, 8'h00};
`ifdef SENSOR_HUB_CHECKSUM_EN
      exp.push_back(8'h3D);
`endif
      wait_tx(exp.size());
      total++; if (txq.size() !== exp.size()) begin bad++; $display("FAIL de_len got=%0d exp=%0d", txq.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
         total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL de_byte%0d got=%h exp=%h", i, txq[i], exp[i]); end
      end
   endtask

   task automatic test_rx_timeout;
      txq.delete();
      send_byte(8'h00);
      tick(20);
      total++; if (debug_state !== S_RX_CMD) begin bad++; $display("FAIL rxto_wait got=%0d exp=%0d", debug_state, S_RX_CMD); end
      tick(30);
      total++; if (debug_state !== S_IDLE) begin bad++; $display("FAIL rxto_idle got=%0d exp=%0d", debug_state, S_IDLE); end
      // a lone 03 is now a foreign address, not a command
      send_byte(8'h03);
      total++; if (debug_state !== S_RX_SKIP) begin bad++; $display("FAIL rxto_skip got=%0d exp=%0d", debug_state, S_RX_SKIP); end
      send_byte(8'h55);
      tick(10);
      total++; if (debug_state !== S_IDLE) begin bad++; $display("FAIL rxto_skip_idle got=%0d exp=%0d", debug_state, S_IDLE); end
      total++; if (txq.size() !== 0) begin bad++; $display("FAIL rxto_no_tx got=%0d exp=0", txq.size()); end
   endtask

   task automatic test_reset_mid_tx;
      int c = 0;
      txq.delete();
      tx_hold = 1'b1;
      send_byte(8'h00);
      send_byte(8'h06);
      while (debug_state !== S_TX_BUSY && c < 20) begin tick(1); c++; end
      tick(2);
      total++; if (debug_state !== S_TX_BUSY) begin bad++; $display("FAIL rst_busy_state got=%0d exp=%0d", debug_state, S_TX_BUSY); end
      total++; if (o_Tx_Start !== 1'b1) begin bad++; $display("FAIL rst_busy_start got=%b exp=1", o_Tx_Start); end
      total++; if (o_Tx_Data !== 8'h2F) begin bad++; $display("FAIL rst_busy_data got=%h exp=2F", o_Tx_Data); end
      i_Reset = 1'b1;
      tick(1);
      total++; if (o_Tx_Start !== 1'b0) begin bad++; $display("FAIL rst_tx_start got=%b exp=0", o_Tx_Start); end
      total++; if (o_Tx_Data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", o_Tx_Data); end
      total++; if (o_Dth_Start !== 4'b0000) begin bad++; $display("FAIL rst_dth got=%b exp=0000", o_Dth_Start); end
      total++; if (debug_state !== S_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", debug_state, S_IDLE); end
      total++; if (debug_rx_Data !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h exp=00", debug_rx_Data); end
      i_Reset = 1'b0;
      tx_hold = 1'b0;
      tick(30);
      total++; if (txq.size() !== 0) begin bad++; $display("FAIL rst_no_tx got=%0d exp=0", txq.size()); end
   endtask

   initial begin
      test_reset;
      test_temp;
      test_skip_status;
      test_cmd_err;
      test_sns_timeout;
      test_done_and_error;
      test_rx_timeout;
      test_reset_mid_tx;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
